// File: rtl/chain_pkg.sv
// Shared types for the daisy-chain return end: sequence states, default stage record layout,
// and the drop counter ceiling.
package chain_pkg;

  localparam int CHAIN_LENGTH_DEF = 8;
  localparam int DATA_W_DEF       = 16;
  localparam int IDX_W_DEF        = $clog2(CHAIN_LENGTH_DEF + 1);

  localparam logic [7:0] DROP_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    ERR
  } seq_state_t;

  // Stage record at the default chain geometry
  typedef struct packed {
    logic [IDX_W_DEF-1:0]  idx;
    logic [DATA_W_DEF-1:0] data;
  } stage_rec_t;

endpackage

// File: rtl/chain_ret_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one wrap bit so full and empty
// are told apart without a separate counter.
module chain_ret_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 20,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
  end

  assign level   = LW'(wptr - rptr);
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // Head is forced to zero when empty so stale storage never shows on the return port
  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/chain_return.sv
// Terminating end of the stage-enable chain: sequence check, return FIFO to upstream,
// frame/error pulses and overflow accounting.
module chain_return #(
  parameter int CHAIN_LENGTH = 8,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 8,
  parameter int IDX_W        = $clog2(CHAIN_LENGTH + 1),
  localparam int LW          = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sense_ena,
  input  logic [IDX_W-1:0]  sense_idx,
  input  logic [DATA_W-1:0] sense_data,
  output logic              ret_valid,
  input  logic              ret_ready,
  output logic [IDX_W-1:0]  ret_idx,
  output logic [DATA_W-1:0] ret_data,
  output logic [LW-1:0]     level,
  input  logic              clr,
  output logic              ovf,
  output logic [7:0]        drop_cnt,
  output logic              frame_done,
  output logic              seq_err,
  output logic [15:0]       frame_cnt
);
  import chain_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LENGTH - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    push;
  logic                    drop;
  logic [IDX_W+DATA_W-1:0] head;
  seq_state_t              state;
  logic [IDX_W-1:0]        exp_idx;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts when drained
  assign pop  = ret_valid & ret_ready;
  assign push = sense_ena & (~full | pop);
  assign drop = sense_ena & full & ~pop;

  chain_ret_fifo #(
    .DEPTH (DEPTH),
    .W     (IDX_W + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({sense_idx, sense_data}),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign ret_valid           = ~empty;
  assign {ret_idx, ret_data} = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      ovf      <= drop;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf      <= 1'b1;
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Sequence tracker sees every record, accepted or dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      exp_idx    <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      if (sense_ena) begin
        case (state)
          IDLE: begin
            if (sense_idx == '0) begin
              if (CHAIN_LENGTH == 1) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
              end else begin
                state   <= COLLECT;
                exp_idx <= ONE_IDX;
              end
            end else begin
              seq_err <= 1'b1;
              state   <= ERR;
            end
          end
          COLLECT: begin
            if (sense_idx == exp_idx) begin
              if (exp_idx == LAST_IDX) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
                state      <= IDLE;
              end else begin
                exp_idx <= exp_idx + 1'b1;
              end
            end else if (sense_idx == '0) begin
              seq_err <= 1'b1;
              exp_idx <= ONE_IDX;
            end else begin
              seq_err <= 1'b1;
              state   <= ERR;
            end
          end
          ERR: begin
            if (sense_idx == '0) begin
              state   <= COLLECT;
              exp_idx <= ONE_IDX;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chain_return.sv
// Randomised and directed bench for chain_return with a queue-based reference model and a
// decoupled return-channel scoreboard.
module tb_chain_return;
  localparam int CL    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int IW    = $clog2(CL + 1);
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          sense_ena;
  logic [IW-1:0] sense_idx;
  logic [DW-1:0] sense_data;
  logic          ret_valid;
  logic          ret_ready;
  logic [IW-1:0] ret_idx;
  logic [DW-1:0] ret_data;
  logic [LW-1:0] level;
  logic          clr;
  logic          ovf;
  logic [7:0]    drop_cnt;
  logic          frame_done;
  logic          seq_err;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  chain_return #(
    .CHAIN_LENGTH (CL),
    .DATA_W       (DW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sense_ena  (sense_ena),
    .sense_idx  (sense_idx),
    .sense_data (sense_data),
    .ret_valid  (ret_valid),
    .ret_ready  (ret_ready),
    .ret_idx    (ret_idx),
    .ret_data   (ret_data),
    .level      (level),
    .clr        (clr),
    .ovf        (ovf),
    .drop_cnt   (drop_cnt),
    .frame_done (frame_done),
    .seq_err    (seq_err),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } rec_t;

  rec_t exp_q[$];
  int   vecs = 0;
  int   errs = 0;

  // Reference model state
  int          m_cnt    = 0;
  bit          m_ovf    = 0;
  int          m_drops  = 0;
  bit          m_done   = 0;
  bit          m_err    = 0;
  logic [15:0] m_frames = '0;
  int          m_pos    = 0;
  bit          m_in_err = 0;
  bit          m_fresh  = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_outputs();
    chk("ret_valid", ret_valid, m_cnt > 0);
    chk("level", level, m_cnt);
    chk("ovf", ovf, m_ovf);
    chk("drop_cnt", drop_cnt, m_drops);
    chk("frame_done", frame_done, m_done);
    chk("seq_err", seq_err, m_err);
    chk("frame_cnt", frame_cnt, m_frames);
    if (m_fresh) begin
      chk("ret_idx_reset", ret_idx, 0);
      chk("ret_data_reset", ret_data, 0);
    end
  endtask

  task automatic model_step(input bit ena, input int idx, input int data,
                            input bit rdy, input bit c, input bit r);
    bit pop, acc, drp;
    if (r) begin
      m_cnt = 0; m_ovf = 0; m_drops = 0; m_done = 0; m_err = 0;
      m_frames = '0; m_pos = 0; m_in_err = 0; m_fresh = 1;
      exp_q.delete();
      return;
    end
    m_fresh = 0;
    pop = (m_cnt > 0) && rdy;
    acc = ena && ((m_cnt < DEPTH) || pop);
    drp = ena && !acc;
    if (acc) exp_q.push_back('{IW'(idx), DW'(data)});
    m_cnt = m_cnt + int'(acc) - int'(pop);
    if (c) begin
      m_ovf = 0;
      m_drops = 0;
    end
    if (drp) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
    m_done = 0;
    m_err  = 0;
    if (ena) begin
      // m_pos counts in-order records of the current frame; 0 means no frame open
      if (idx == 0) begin
        if (m_pos > 0) m_err = 1;
        m_in_err = 0;
        m_pos    = 1;
      end else if (!m_in_err && m_pos > 0 && idx == m_pos) begin
        m_pos++;
      end else if (!m_in_err) begin
        m_err    = 1;
        m_in_err = 1;
        m_pos    = 0;
      end
      if (m_pos == CL) begin
        m_done = 1;
        m_frames++;
        m_pos = 0;
      end
    end
  endtask

  task automatic cyc(input bit ena, input int idx, input int data,
                     input bit rdy, input bit c, input bit r);
    @(posedge clk);
    #1;
    check_outputs();
    sense_ena  = ena;
    sense_idx  = IW'(idx);
    sense_data = DW'(data);
    ret_ready  = rdy;
    clr        = c;
    rst        = r;
    model_step(ena, idx, data, rdy, c, r);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, rdy, 0, 0);
  endtask

  // Scoreboard monitor: a handshake visible at the falling edge completes on the next rise
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && ret_valid === 1'b1 && ret_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL ret_pop: got idx %0d data %0h, required no record", ret_idx, ret_data);
        end else begin
          r = exp_q.pop_front();
          chk("ret_idx", ret_idx, r.idx);
          chk("ret_data", ret_data, r.data);
        end
      end
    end
  end

  initial begin
    int seq[12];
    int nidx;
    sense_ena = 0; sense_idx = '0; sense_data = '0;
    ret_ready = 0; clr = 0; rst = 1;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Single clean frame with the return channel open
    for (int i = 0; i < CL; i++) cyc(1, i, 'h100 + i, 1, 0, 0);
    idle(4, 1);

    // Overflow: ten records into eight slots, then drain and clear
    for (int i = 0; i < 10; i++) cyc(1, i % CL, 'h200 + i, 0, 0, 0);
    idle(2, 0);
    idle(10, 1);
    cyc(0, 0, 0, 1, 1, 0);
    idle(2, 1);

    // Full FIFO accepts a push when a pop happens in the same cycle
    for (int i = 0; i < CL; i++) cyc(1, i, 'h300 + i, 0, 0, 0);
    cyc(1, 0, 'h3ff, 1, 0, 0);
    idle(10, 1);

    // Out-of-order sequence with recovery on idx 0
    seq = '{0, 1, 3, 4, 0, 1, 2, 3, 4, 5, 6, 7};
    for (int i = 0; i < 12; i++) cyc(1, seq[i], 'h400 + i, 1, 0, 0);
    idle(3, 1);

    // Reset mid-frame, then a full frame from scratch
    for (int i = 0; i < 3; i++) cyc(1, i, 'h500 + i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < CL; i++) cyc(1, i, 'h600 + i, 1, 0, 0);
    idle(3, 1);

    // Illegal index, then drop counter saturation
    cyc(1, 9, 'h700, 1, 0, 0);
    idle(2, 1);
    for (int i = 0; i < DEPTH + 300; i++) cyc(1, i % CL, 'h800 + i, 0, 0, 0);
    idle(2, 0);
    idle(10, 1);

    // Random traffic, mostly in-order indices with occasional faults
    nidx = 0;
    for (int i = 0; i < 1500; i++) begin
      int idx;
      bit ena;
      ena = ($urandom_range(99) < 80);
      if ($urandom_range(99) < 85) idx = nidx;
      else idx = $urandom_range(CL + 1);
      if (ena) nidx = (idx + 1) % CL;
      cyc(ena, idx, $urandom, ($urandom_range(99) < 70), ($urandom_range(99) < 3), 0);
    end
    idle(DEPTH + 4, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
